// File: rtl/fd_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO feeding a registered decode (D) stage.
// Define FDQ_BYPASS_EN to let a fetch word load D directly when the queue is empty and unstalled.
module fd_queue #(
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1),
    parameter int VALC_W = 64,
    parameter int VALP_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_valid,
    output logic              f_ready,
    input  logic [2:0]        f_stat,
    input  logic [3:0]        f_Ins_Code,
    input  logic [3:0]        f_Ins_fun,
    input  logic [3:0]        f_rA,
    input  logic [3:0]        f_rB,
    input  logic [VALC_W-1:0] f_Val_C,
    input  logic [VALP_W-1:0] f_Val_P,
    input  logic              D_toBubble,
    input  logic              D_tostall,
    output logic              D_valid,
    output logic [2:0]        D_stat,
    output logic [3:0]        D_Ins_Code,
    output logic [3:0]        D_Ins_fun,
    output logic [3:0]        D_rA,
    output logic [3:0]        D_rB,
    output logic [VALC_W-1:0] D_Val_C,
    output logic [VALP_W-1:0] D_Val_P,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 3 + 4 * 4 + VALC_W + VALP_W;
    localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [ENTRY_W-1:0] NOP_WORD  =
        {3'd0, 4'd1, 4'd0, 4'hF, 4'hF, {VALC_W{1'b0}}, {VALP_W{1'b0}}};

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] d_word;
    logic [ENTRY_W-1:0] f_word;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count_q;
    logic               d_valid_q;
    logic               bypass;
    logic               push;
    logic               pop;

    assign f_word  = {f_stat, f_Ins_Code, f_Ins_fun, f_rA, f_rB, f_Val_C, f_Val_P};
    assign f_ready = (count_q < DEPTH_CNT);

`ifdef FDQ_BYPASS_EN
    assign bypass = f_valid && (count_q == '0) && !D_tostall && !D_toBubble;
`else
    assign bypass = 1'b0;
`endif

    // A bubble flushes, so the word offered alongside it is dropped rather than stored.
    assign push = f_valid && f_ready && !bypass && !D_toBubble;
    assign pop  = !D_toBubble && !D_tostall && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= f_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || D_toBubble) begin
            d_word    <= NOP_WORD;
            d_valid_q <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count_q   <= '0;
        end else begin
            if (pop) begin
                d_word    <= mem[head];
                d_valid_q <= 1'b1;
                head      <= head + 1'b1;
            end else if (!D_tostall) begin
                d_word    <= bypass ? f_word : NOP_WORD;
                d_valid_q <= bypass;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            // Simultaneous push and pop leave occupancy unchanged.
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign {D_stat, D_Ins_Code, D_Ins_fun, D_rA, D_rB, D_Val_C, D_Val_P} = d_word;
    assign D_valid = d_valid_q;
    assign count   = count_q;

endmodule

// File: doc/fd_queue.md
# fd_queue

Parametrised fetch-to-decode instruction queue for the Y86 pipeline. It generalises the single-entry F/D pipeline register into a DEPTH-entry FIFO with a registered decode-side head, so fetch can keep running while decode stalls. It keeps the existing stall and bubble semantics (bubble inserts a nop, stall holds). It adds a ready/valid handshake on the fetch side, flush-on-bubble and occupancy reporting.

## Interface
Parameters:
- DEPTH, 4, queue entries behind the D register; power of two, ≥2
- CNT_W, $clog2(DEPTH+1), width of occupancy count
- VALC_W, 64, width of Val_C
- VALP_W, 64, width of Val_P

Ports:
- clk  in  1  rising-edge clock; one clock domain, synchronous active-high reset
- rst  in  1  synchronous, active-high reset
- f_valid  in  1  fetch presents an instruction this cycle
- f_ready  out  1  queue accepts; = (count < DEPTH), combinational from registered count
- f_stat  in  3  fetch status
- f_Ins_Code  in  4  icode
- f_Ins_fun  in  4  ifun
- f_rA  in  4  rA
- f_rB  in  4  rB
- f_Val_C  in  VALC_W  signed constant word
- f_Val_P  in  VALP_W  next PC
- D_toBubble  in  1  flush queue, load nop into D
- D_tostall  in  1  hold D register
- D_valid  out  1  D holds a real (fetched) instruction
- D_stat, D_Ins_Code, D_Ins_fun, D_rA, D_rB, D_Val_C, D_Val_P  out  3/4/4/4/4/VALC_W/VALP_W  registered decode-stage fields
- count  out  CNT_W  queue occupancy, excludes D register

## Operation
- Nop bubble value: Ins_Code=4'd1, Ins_fun=0, stat=0, rA=rB=4'hF, Val_C=0, Val_P=0, D_valid=0.
- Push: f_valid && f_ready, not bypassed (see Configuration), not bubble → entry written at tail; tail and count advance.
- Priority at each posedge: rst > D_toBubble > D_tostall > normal.
- rst: D ← nop bubble; head=tail=count=0. Storage contents are don't-care.
- D_toBubble (stall ignored): D ← nop bubble; queue cleared (count=0). The fetch word offered this cycle is dropped; f_ready is still high, so fetch must treat the bubble as a flush.
- D_tostall: D unchanged; no pop. A push still occurs if not full.
- Normal, count>0: D ← head entry, D_valid=1, pop. A push may occur in the same cycle, and count is then unchanged.
- Normal, count=0: D ← bypassed fetch word if enabled and f_valid. Otherwise D ← nop bubble.
- Full: f_ready=0 even if a pop occurs that cycle; no same-cycle refill at full.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count never exceeds DEPTH and never underflows.

## Timing
- All outputs are registered except f_ready. Nothing changes between edges.
- Latency f_valid→D: 2 edges through the queue. With bypass and an empty, unstalled queue, latency is 1 edge.
- Throughput is 1 instruction/cycle when decode is unstalled and the queue is not full.
- Stall for N cycles with fetch streaming: queue fills in DEPTH cycles, then f_ready=0. Drain begins the edge after stall drops.
- Bubble takes effect in 1 edge. On the following cycle count=0 and f_ready=1.

## Configuration
- FDQ_BYPASS_EN defined: when count=0, not stalled and not bubbling, a valid fetch word loads D directly on the same edge and is not pushed.
- FDQ_BYPASS_EN undefined: every instruction passes through storage, so D is never loaded from f_* directly. Minimum latency is 2 edges.

## Test plan
- Reset: assert rst 2 cycles with f_valid=1 → D_Ins_Code=1, D_valid=0, count=0, f_ready=1; no push recorded.
- Streaming: with D_tostall=0, push icodes 3,4,5,6 on consecutive cycles → D shows 3,4,5,6 on consecutive edges. First D arrival is at edge 2 without bypass and edge 1 with FDQ_BYPASS_EN.
- Stall fill/drain (DEPTH=4): hold stall while pushing 6 words → D constant, count=4, f_ready=0 after 4 pushes. Release stall → D shows words in order, and words 5 and 6 are accepted once count<4.
- Bubble flush: count=3, then assert D_toBubble with stall=1 and f_valid=1 → next edge D_Ins_Code=1, D_valid=0, count=0; the offered word never appears on D.
- Wrap: push/pop 3·DEPTH+1 words with random stall → output order equals input order, and count matches a reference model every cycle.
- Empty with no fetch: count=0, f_valid=0, no stall → D ← nop bubble each edge, D_valid=0.
